// File: rtl/aes_pkg.sv
// Shared AES datapath types, constants and byte helpers for the round pipeline.
package aes_pkg;

    localparam logic [7:0] XTIME_POLY = 8'h1b;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] col_t;

    typedef enum logic [1:0] {IDLE, CALC, DONE} mc_state_t;

    // Byte 0 is the most significant byte of the column.
    function automatic byte_t col_byte(col_t col, logic [1:0] idx);
        byte_t b;
        case (idx)
            2'd0:    b = col[31:24];
            2'd1:    b = col[23:16];
            2'd2:    b = col[15:8];
            default: b = col[7:0];
        endcase
        return b;
    endfunction

    function automatic col_t col_pack(byte_t b0, byte_t b1, byte_t b2, byte_t b3);
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/mixcol_sched_if.sv
// Valid/ready column interface between the round controller and the MixColumns engine.
interface mixcol_sched_if;
    import aes_pkg::*;

    logic in_valid;
    logic in_ready;
    col_t in_col;
    logic out_valid;
    logic out_ready;
    col_t out_col;
    logic busy;

    modport master (
        output in_valid, in_col, out_ready,
        input  in_ready, out_valid, out_col, busy
    );

    modport slave (
        input  in_valid, in_col, out_ready,
        output in_ready, out_valid, out_col, busy
    );

endinterface

// File: rtl/gf_xtime.sv
// Combinational GF(2^8) multiply-by-two over the AES field polynomial.
module gf_xtime
    import aes_pkg::*;
(
    input  byte_t x,
    output byte_t y
);

    assign y = {x[6:0], 1'b0} ^ (x[7] ? XTIME_POLY : 8'h00);

endmodule

// File: rtl/mixcol_sched.sv
// Iterative forward MixColumns for one column, sharing N_XT xtime units across
// the four output bytes; one column takes 4/N_XT compute cycles.
module mixcol_sched
    import aes_pkg::*;
#(
    parameter int N_XT = 1
)
(
    input  logic           clk,
    input  logic           rst_n,
    mixcol_sched_if.slave  bus
);

    localparam int NC = 4 / N_XT;
    localparam logic [1:0] LAST_CNT = 2'(NC - 1);

    if (!(N_XT == 1 || N_XT == 2 || N_XT == 4)) begin : g_bad_n_xt
        $error("mixcol_sched: N_XT must be 1, 2 or 4");
    end

    mc_state_t state;
    mc_state_t state_next;
    col_t      col_reg;
    col_t      res_reg;
    col_t      res_next;
    col_t      out_reg;
    logic [1:0] cnt;
    logic      load;
    logic      calc;
    logic      last;
    logic      in_ready;
    logic      out_valid;
    logic      busy;

    logic [N_XT-1:0][7:0] new_byte;
    logic [N_XT-1:0][1:0] new_idx;

    // Unit k produces output byte cnt*N_XT+k from the rotated input bytes.
    for (genvar k = 0; k < N_XT; k++) begin : g_xt
        logic [1:0] idx;
        byte_t a0, a1, a2, a3, xo;

        always_comb begin
            idx = 2'(int'(cnt) * N_XT + k);
            a0  = col_byte(col_reg, idx);
            a1  = col_byte(col_reg, idx + 2'd1);
            a2  = col_byte(col_reg, idx + 2'd2);
            a3  = col_byte(col_reg, idx + 2'd3);
        end

        gf_xtime u_xtime (
            .x (a0 ^ a1),
            .y (xo)
        );

        assign new_byte[k] = xo ^ a1 ^ a2 ^ a3;
        assign new_idx[k]  = idx;
    end

    always_comb begin
        res_next = res_reg;
        for (int k = 0; k < N_XT; k++) begin
            case (new_idx[k])
                2'd0:    res_next[31:24] = new_byte[k];
                2'd1:    res_next[23:16] = new_byte[k];
                2'd2:    res_next[15:8]  = new_byte[k];
                default: res_next[7:0]   = new_byte[k];
            endcase
        end
    end

    assign last = (cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // In DONE a new column is taken in the same cycle as the output handshake.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        load       = 1'b0;
        calc       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    load       = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                calc = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                in_ready  = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        load       = 1'b1;
                        state_next = CALC;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // out_reg is only written on the final compute cycle, so it never moves while valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg <= '0;
            res_reg <= '0;
            out_reg <= '0;
            cnt     <= '0;
        end else begin
            if (load) begin
                col_reg <= bus.in_col;
                cnt     <= '0;
            end
            if (calc) begin
                res_reg <= res_next;
                cnt     <= cnt + 2'd1;
                if (last) begin
                    out_reg <= res_next;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_col   = out_reg;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_mixcol_sched.sv
// Directed and randomised checks of mixcol_sched with N_XT = 1, 2 and 4 side by side.
module tb_mixcol_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic [2:0]       in_valid_d = '0;
    logic [2:0]       out_ready_d = '1;
    logic [2:0][31:0] in_col_d = '0;
    logic [2:0]       in_ready_v;
    logic [2:0]       out_valid_v;
    logic [2:0]       busy_v;
    logic [2:0][31:0] out_col_v;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    // Instance g drives the engine built with N_XT = 1 << g.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        mixcol_sched_if bus ();

        assign bus.in_valid   = in_valid_d[g];
        assign bus.in_col     = in_col_d[g];
        assign bus.out_ready  = out_ready_d[g];
        assign in_ready_v[g]  = bus.in_ready;
        assign out_valid_v[g] = bus.out_valid;
        assign out_col_v[g]   = bus.out_col;
        assign busy_v[g]      = bus.busy;

        mixcol_sched #(.N_XT(1 << g)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    function automatic logic [7:0] mul2(logic [7:0] x);
        logic [7:0] s;
        s = {x[6:0], 1'b0};
        return x[7] ? (s ^ 8'h1b) : s;
    endfunction

    function automatic logic [31:0] ref_mixcol(logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) a[i] = c[31 - 8*i -: 8];
        for (int i = 0; i < 4; i++)
            b[i] = mul2(a[i]) ^ mul2(a[(i+1)%4]) ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
        return {b[0], b[1], b[2], b[3]};
    endfunction

    task automatic do_reset();
        in_valid_d  = '0;
        out_ready_d = '1;
        in_col_d    = '0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_valid_d  = '0;
        out_ready_d = '1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (in_ready_v[d] !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL reset_in_ready d%0d got %b exp 1", d, in_ready_v[d]);
            end
            vectors++;
            if (out_valid_v[d] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_out_valid d%0d got %b exp 0", d, out_valid_v[d]);
            end
            vectors++;
            if (busy_v[d] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_busy d%0d got %b exp 0", d, busy_v[d]);
            end
            vectors++;
            if (out_col_v[d] !== 32'h0) begin
                miscompares++;
                $display("[TB] FAIL reset_out_col d%0d got %h exp 00000000", d, out_col_v[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_kat(int d, logic [31:0] c, logic [31:0] expv);
        int nc;
        nc = 4 >> d;
        @(negedge clk);
        in_valid_d[d] = 1'b1;
        in_col_d[d]   = c;
        vectors++;
        if (in_ready_v[d] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL kat_in_ready d%0d got %b exp 1", d, in_ready_v[d]);
        end
        @(posedge clk);
        #1;
        in_valid_d[d] = 1'b0;
        for (int e = 1; e <= nc; e++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (out_valid_v[d] !== (e == nc)) begin
                miscompares++;
                $display("[TB] FAIL kat_latency d%0d edge %0d got %b exp %b", d, e, out_valid_v[d], (e == nc));
            end
        end
        vectors++;
        if (out_col_v[d] !== expv) begin
            miscompares++;
            $display("[TB] FAIL kat_value d%0d in %h got %h exp %h", d, c, out_col_v[d], expv);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid_v[d] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL kat_pulse_width d%0d got %b exp 0", d, out_valid_v[d]);
        end
    endtask

    task automatic test_known_answer();
        logic [31:0] ins  [5];
        logic [31:0] outs [5];
        ins[0] = 32'hdb135345; outs[0] = 32'h8e4da1bc;
        ins[1] = 32'hf20a225c; outs[1] = 32'h9fdc589d;
        ins[2] = 32'hd4bf5d30; outs[2] = 32'h046681e5;
        ins[3] = 32'h01010101; outs[3] = 32'h01010101;
        ins[4] = 32'hc6c6c6c6; outs[4] = 32'hc6c6c6c6;
        for (int d = 0; d < 3; d++) begin
            do_reset();
            for (int v = 0; v < 5; v++) run_kat(d, ins[v], outs[v]);
        end
    endtask

    task automatic test_backpressure(int d);
        int nc;
        int xfers;
        nc = 4 >> d;
        do_reset();
        out_ready_d[d] = 1'b0;
        @(negedge clk);
        in_valid_d[d] = 1'b1;
        in_col_d[d]   = 32'hdb135345;
        @(posedge clk);
        #1;
        in_valid_d[d] = 1'b0;
        repeat (nc) @(posedge clk);
        #1;
        in_valid_d[d] = 1'b1;
        in_col_d[d]   = 32'hf20a225c;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (out_valid_v[d] !== 1'b1 || out_col_v[d] !== 32'h8e4da1bc || in_ready_v[d] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL stall_hold d%0d cyc %0d valid %b col %h ready %b exp 1 8e4da1bc 0",
                         d, i, out_valid_v[d], out_col_v[d], in_ready_v[d]);
            end
        end
        @(posedge clk);
        #1;
        in_valid_d[d]  = 1'b0;
        out_ready_d[d] = 1'b1;
        xfers = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid_v[d] && out_ready_d[d]) xfers++;
        end
        vectors++;
        if (xfers != 1) begin
            miscompares++;
            $display("[TB] FAIL stall_release_xfers d%0d got %0d exp 1", d, xfers);
        end
        vectors++;
        if (busy_v[d] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stall_ignored_input d%0d busy got %b exp 0", d, busy_v[d]);
        end
    endtask

    task automatic test_back_to_back(int d);
        logic [31:0] cols [3];
        logic [31:0] outs [3];
        int nc;
        int nacc;
        int nout;
        int last_out;
        logic acc;
        nc = 4 >> d;
        cols[0] = 32'hdb135345; outs[0] = 32'h8e4da1bc;
        cols[1] = 32'hf20a225c; outs[1] = 32'h9fdc589d;
        cols[2] = 32'hd4bf5d30; outs[2] = 32'h046681e5;
        do_reset();
        nacc = 0;
        nout = 0;
        last_out = -1;
        in_valid_d[d] = 1'b1;
        in_col_d[d]   = cols[0];
        for (int cyc = 0; cyc < 60 && nout < 3; cyc++) begin
            @(negedge clk);
            acc = in_valid_d[d] && in_ready_v[d];
            if (out_valid_v[d]) begin
                vectors++;
                if (out_col_v[d] !== outs[nout]) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_value d%0d #%0d got %h exp %h", d, nout, out_col_v[d], outs[nout]);
                end
                if (nout > 0) begin
                    vectors++;
                    if (cyc - last_out != nc + 1) begin
                        miscompares++;
                        $display("[TB] FAIL b2b_spacing d%0d #%0d got %0d exp %0d", d, nout, cyc - last_out, nc + 1);
                    end
                end
                if (nout < 2) begin
                    vectors++;
                    if (acc !== 1'b1) begin
                        miscompares++;
                        $display("[TB] FAIL b2b_same_cycle_accept d%0d #%0d got %b exp 1", d, nout, acc);
                    end
                end
                last_out = cyc;
                nout++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                nacc++;
                if (nacc < 3) in_col_d[d] = cols[nacc];
                else          in_valid_d[d] = 1'b0;
            end
        end
        in_valid_d[d] = 1'b0;
        vectors++;
        if (nout != 3) begin
            miscompares++;
            $display("[TB] FAIL b2b_count d%0d got %0d exp 3", d, nout);
        end
    endtask

    task automatic test_reset_mid_calc();
        do_reset();
        run_kat(0, 32'hf20a225c, 32'h9fdc589d);
        @(negedge clk);
        in_valid_d[0] = 1'b1;
        in_col_d[0]   = 32'hd4bf5d30;
        @(posedge clk);
        #1;
        in_valid_d[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || out_col_v[0] !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_clear valid %b busy %b col %h exp 0 0 00000000",
                     out_valid_v[0], busy_v[0], out_col_v[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vectors++;
            if (out_valid_v[0] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL mid_reset_stale cyc %0d got %b exp 0", i, out_valid_v[0]);
            end
        end
        @(posedge clk);
        #1;
        run_kat(0, 32'hdb135345, 32'h8e4da1bc);
    endtask

    task automatic test_random(int d, int n);
        int got;
        logic prev_stall;
        logic [31:0] prev_col;
        logic [31:0] e;
        do_reset();
        exp_q.delete();
        got = 0;
        prev_stall = 1'b0;
        prev_col = '0;
        fork
            begin : drv
                logic [31:0] c;
                logic hs;
                int guard;
                for (int i = 0; i < n; i++) begin
                    in_valid_d[d] = 1'b0;
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    c = $urandom();
                    in_valid_d[d] = 1'b1;
                    in_col_d[d]   = c;
                    guard = 0;
                    hs = 1'b0;
                    while (!hs && guard < 200) begin
                        @(negedge clk);
                        hs = in_ready_v[d];
                        @(posedge clk);
                        #1;
                        guard++;
                    end
                    if (!hs) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL rand_accept_timeout d%0d col %0d", d, i);
                        break;
                    end
                    exp_q.push_back(ref_mixcol(c));
                end
                in_valid_d[d] = 1'b0;
            end
            begin : mon
                for (int guard = 0; guard < 20000 && got < n; guard++) begin
                    @(posedge clk);
                    #1;
                    out_ready_d[d] = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    if (prev_stall) begin
                        vectors++;
                        if (out_valid_v[d] !== 1'b1 || out_col_v[d] !== prev_col) begin
                            miscompares++;
                            $display("[TB] FAIL rand_stable d%0d valid %b col %h exp 1 %h",
                                     d, out_valid_v[d], out_col_v[d], prev_col);
                        end
                    end
                    if (out_valid_v[d] === 1'b1) begin
                        if (out_ready_d[d]) begin
                            vectors++;
                            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
                            if (out_col_v[d] !== e) begin
                                miscompares++;
                                $display("[TB] FAIL rand_value d%0d #%0d got %h exp %h", d, got, out_col_v[d], e);
                            end
                            got++;
                            prev_stall = 1'b0;
                        end else begin
                            prev_stall = 1'b1;
                            prev_col   = out_col_v[d];
                        end
                    end else begin
                        prev_stall = 1'b0;
                    end
                end
            end
        join
        out_ready_d[d] = 1'b1;
        vectors++;
        if (got != n) begin
            miscompares++;
            $display("[TB] FAIL rand_count d%0d got %0d exp %0d", d, got, n);
        end
    endtask

    initial begin
        test_reset();
        test_known_answer();
        for (int d = 0; d < 3; d++) test_backpressure(d);
        for (int d = 0; d < 3; d++) test_back_to_back(d);
        test_reset_mid_calc();
        test_random(0, 334);
        test_random(1, 333);
        test_random(2, 333);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
